// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and defaults for the fetch/load-store memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int ARB_AW             = 8;
  localparam int ARB_DW             = 16;
  localparam int ARB_STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_D  = 1'b1
  } arb_src_e;

  // Data wins ties because a data stall blocks retirement, unless fetch has been starved.
  function automatic logic pick_data(input logic if_req, input logic d_req,
                                     input logic prefer_if);
    return d_req && !(if_req && prefer_if);
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts data grants issued while a fetch waits; flags when fetch must win the next tie.
module mem_arb_starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = ARB_STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic pcrst,
  input  logic if_req,
  input  logic if_gnt,
  input  logic d_gnt,
  output logic prefer_if
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;

  always_ff @(posedge clk or posedge pcrst) begin
    if (pcrst) begin
      starve_cnt <= '0;
    end else if (if_gnt || !if_req) begin
      starve_cnt <= '0;
    end else if (d_gnt && (starve_cnt != SW'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  assign prefer_if = (starve_cnt == SW'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous RAM port between instruction fetch and load/store, one access at a time.
// Define ARB_STARVE_GUARD_EN to let a starved fetch win a tie after STARVE_MAX data grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW         = ARB_AW,
  parameter int DW         = ARB_DW,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = ARB_STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          pcrst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = $clog2(MEM_LAT + 1);

  arb_state_e    state;
  arb_src_e      cmd_src;
  logic          cmd_we;
  logic [CW-1:0] wait_cnt;
  logic          prefer_if;
  logic          d_win;

`ifdef ARB_STARVE_GUARD_EN
  mem_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .pcrst    (pcrst),
    .if_req   (if_req),
    .if_gnt   (if_gnt),
    .d_gnt    (d_gnt),
    .prefer_if(prefer_if)
  );
`else
  logic unused_starve_max;
  assign prefer_if         = 1'b0;
  assign unused_starve_max = (STARVE_MAX > 0);
`endif

  assign d_win = pick_data(if_req, d_req, prefer_if);

  // Outputs are computed one state ahead so they are registered in the state they belong to.
  always_ff @(posedge clk or posedge pcrst) begin
    if (pcrst) begin
      state     <= ARB_IDLE;
      cmd_src   <= SRC_IF;
      cmd_we    <= 1'b0;
      wait_cnt  <= '0;
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_gnt     <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (if_req || d_req) begin
            state     <= ARB_ISSUE;
            busy      <= 1'b1;
            cmd_src   <= d_win ? SRC_D : SRC_IF;
            cmd_we    <= d_win && d_we;
            mem_en    <= 1'b1;
            mem_we    <= d_win && d_we;
            mem_addr  <= d_win ? d_addr : if_addr;
            mem_wdata <= d_win ? d_wdata : '0;
            d_gnt     <= d_win;
            if_gnt    <= !d_win;
          end
        end
        ARB_ISSUE: begin
          state    <= ARB_WAIT;
          wait_cnt <= CW'(1);
        end
        ARB_WAIT: begin
          if (wait_cnt == CW'(MEM_LAT)) begin
            state <= ARB_RESP;
            if (cmd_src == SRC_D) begin
              d_rvalid <= 1'b1;
              d_rdata  <= cmd_we ? '0 : mem_rdata;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        ARB_RESP: begin
          state <= ARB_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ARB_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter against a cycle-arithmetic reference model.
module tb_mem_port_arbiter;

  localparam int AW         = 8;
  localparam int DW         = 16;
  localparam int MEM_LAT    = 1;
  localparam int STARVE_MAX = 4;

  logic          clk = 1'b0;
  logic          pcrst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .pcrst(pcrst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Environment RAM: fixed initial contents, read-first, one cycle read latency.
  logic [DW-1:0] ram_w [256];
  bit            ram_set [256];

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 8'h10) return 16'h1234;
    return {a ^ 8'hA5, ~a};
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram_w[mem_addr]   <= mem_wdata;
        ram_set[mem_addr] <= 1'b1;
      end
      mem_rdata <= ram_set[mem_addr] ? ram_w[mem_addr] : init_val(mem_addr);
    end
  end

  // Reference model: one access record, timed by plain cycle arithmetic.
  int            cyc = 0;
  int            m_issue = -100;
  int            m_resp = -100;
  bit            m_src_d, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  int            m_starve = 0;
  logic [DW-1:0] ref_mem [int];
  bit            rst_seen;
  bit            rst_cmd = 1'b1;

  bit if_pend, d_pend, d_auto, rnd_mode;
  int n_if_gnt, n_d_gnt, d_before_if;
  int n_assert = 0;
  int n_fail = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_cycle();
    bit iss, rsp;
    iss = (cyc == m_issue);
    rsp = (cyc == m_resp);
    chk1("if_gnt",    if_gnt,    iss && !m_src_d);
    chk1("d_gnt",     d_gnt,     iss && m_src_d);
    chk1("mem_en",    mem_en,    iss);
    chk1("mem_we",    mem_we,    iss && m_we);
    chk1("if_rvalid", if_rvalid, rsp && !m_src_d);
    chk1("d_rvalid",  d_rvalid,  rsp && m_src_d);
    chk1("busy",      busy,      (cyc >= m_issue) && (cyc <= m_resp));
    if (iss) chkw("mem_addr", {8'h00, mem_addr}, {8'h00, m_addr});
    if (iss && m_we) chkw("mem_wdata", mem_wdata, m_wdata);
    if (rsp && !m_src_d) chkw("if_rdata", if_rdata, m_rdata);
    if (rsp && m_src_d) chkw("d_rdata", d_rdata, m_rdata);
    if (rst_seen) begin
      chkw("rst_mem_addr",  {8'h00, mem_addr}, 16'h0000);
      chkw("rst_mem_wdata", mem_wdata, 16'h0000);
      chkw("rst_if_rdata",  if_rdata,  16'h0000);
      chkw("rst_d_rdata",   d_rdata,   16'h0000);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
    rst_seen = pcrst;
    check_cycle();
    if (if_gnt) n_if_gnt++;
    if (d_gnt) begin
      n_d_gnt++;
      if (n_if_gnt == 0) d_before_if++;
    end
    if (cyc == m_issue) begin
      if (m_src_d) d_pend = 1'b0;
      else if_pend = 1'b0;
    end
  endtask

  task automatic commit();
    bit take_d;
    if (pcrst) begin
      m_issue  = -100;
      m_resp   = -100;
      m_starve = 0;
      return;
    end
    if ((cyc > m_resp) && (if_req || d_req)) begin
      take_d = d_req;
`ifdef ARB_STARVE_GUARD_EN
      if (if_req && (m_starve >= STARVE_MAX)) take_d = 1'b0;
`endif
      m_src_d = take_d;
      m_we    = take_d && d_we;
      m_addr  = take_d ? d_addr : if_addr;
      m_wdata = d_wdata;
      if (m_we) begin
        m_rdata = '0;
        ref_mem[int'(m_addr)] = d_wdata;
      end else begin
        m_rdata = ref_mem.exists(int'(m_addr)) ? ref_mem[int'(m_addr)] : init_val(m_addr);
      end
      m_issue = cyc + 1;
      m_resp  = cyc + MEM_LAT + 2;
    end
    if (!if_req || ((cyc == m_issue) && !m_src_d)) m_starve = 0;
    else if ((cyc == m_issue) && m_src_d && (m_starve < STARVE_MAX)) m_starve++;
  endtask

  task automatic post_if(input logic [AW-1:0] a);
    if_pend = 1'b1;
    if_addr = a;
  endtask

  task automatic post_d(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    d_pend  = 1'b1;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
  endtask

  task automatic step();
    advance();
    if (d_auto && !d_pend) post_d(1'b0, 8'($urandom), 16'h0000);
    if (rnd_mode) begin
      if (!if_pend && ($urandom_range(0, 2) == 0)) post_if(8'($urandom_range(0, 15)));
      if (!d_pend && ($urandom_range(0, 2) == 0))
        post_d(1'($urandom), 8'($urandom_range(0, 15)), 16'($urandom));
      if (if_pend && ($urandom_range(0, 15) == 0)) if_pend = 1'b0;
      if (d_pend && ($urandom_range(0, 15) == 0)) d_pend = 1'b0;
    end
    pcrst  = rst_cmd;
    if_req = if_pend;
    d_req  = d_pend;
    commit();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset held three cycles while requests toggle.
    rst_cmd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if_pend = 1'($urandom);
      d_pend  = 1'($urandom);
      if_addr = 8'($urandom);
      d_addr  = 8'($urandom);
      step();
    end
    if_pend = 1'b0;
    d_pend  = 1'b0;
    rst_cmd = 1'b0;
    run(3);

    // Single fetch of a known word.
    post_if(8'h10);
    run(6);

    // Tie: data wins, fetch follows.
    post_d(1'b0, 8'h20, 16'h0000);
    post_if(8'h44);
    run(10);

    // Write then read back the same address.
    post_d(1'b1, 8'h20, 16'hBEEF);
    run(5);
    post_d(1'b0, 8'h20, 16'h0000);
    run(5);

    // Both requesters held continuously.
    n_if_gnt    = 0;
    n_d_gnt     = 0;
    d_before_if = 0;
    post_if(8'h30);
    d_auto = 1'b1;
    run(30);
`ifdef ARB_STARVE_GUARD_EN
    chkw("starve_d_before_if", 16'(d_before_if), 16'd4);
    chk1("starve_if_granted", n_if_gnt > 0, 1'b1);
`else
    chkw("starve_if_gnts", 16'(n_if_gnt), 16'd0);
    chk1("starve_d_grants", n_d_gnt >= 6, 1'b1);
`endif
    d_auto = 1'b0;
    run(12);
    chk1("if_after_d_drop", n_if_gnt > 0, 1'b1);
    run(4);

    // Reset pulse in the WAIT cycle of a fetch.
    post_if(8'h55);
    step();
    step();
    rst_cmd = 1'b1;
    step();
    rst_cmd = 1'b0;
    step();
    run(5);
    post_if(8'h56);
    run(6);

    // Randomised traffic with occasional abandoned requests.
    rnd_mode = 1'b1;
    run(400);
    rnd_mode = 1'b0;
    if_pend  = 1'b0;
    d_pend   = 1'b0;
    run(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
